// File: rtl/phase_window_timer.sv
// phase_window_timer
// Free-running phase counter that counts clk cycles modulo PERIOD, pulses
// wrap at each period boundary, counts completed periods (saturating) and
// drives NCH gate outputs. Each gate is high inside a [start, stop) phase
// window. Window settings are written into shadow registers and copied to
// the active set only at a period boundary, either a natural wrap or a
// sync_clear, so a timing change never takes effect mid-period.

module phase_window_timer #(
    parameter int NBITS  = 27,
    parameter int PERIOD = 96830000,
    parameter int NCH    = 4,
    parameter int CHW    = 2,
    parameter int CYCW   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              sync_clear,
    input  logic              cfg_we,
    input  logic [CHW-1:0]    cfg_ch,
    input  logic [NBITS-1:0]  cfg_start,
    input  logic [NBITS-1:0]  cfg_stop,
    output logic [NBITS-1:0]  count_out,
    output logic              wrap,
    output logic [CYCW-1:0]   cycle_count,
    output logic [NCH-1:0]    ch_out
);

    // Last phase of the period; the counter returns to 0 after it.
    localparam logic [NBITS-1:0] LAST_PHASE = NBITS'(PERIOD - 1);
    // Saturation value of the completed-period counter.
    localparam logic [CYCW-1:0]  CYC_MAX    = {CYCW{1'b1}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NBITS-1:0] phase_q;
    logic             wrap_q;
    logic [CYCW-1:0]  cycles_q;
    logic [NCH-1:0]   gate_q;

    logic [NBITS-1:0] shadow_start [NCH];
    logic [NBITS-1:0] shadow_stop  [NCH];
    logic [NBITS-1:0] active_start [NCH];
    logic [NBITS-1:0] active_stop  [NCH];

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic             at_last;
    logic             wrap_evt;
    logic             transfer;
    logic [NBITS-1:0] shadow_start_nxt [NCH];
    logic [NBITS-1:0] shadow_stop_nxt  [NCH];
    logic [NCH-1:0]   in_window;

    // A natural wrap happens only when counting at the last phase and no
    // sync_clear overrides it; either boundary event copies shadow to active.
    always_comb begin
        at_last  = (phase_q == LAST_PHASE);
        wrap_evt = enable && at_last && !sync_clear;
        transfer = sync_clear || wrap_evt;
    end

    // Shadow values after this cycle's write, forwarded so a write landing on
    // a transfer edge is included in that transfer. Indices >= NCH never match.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // through the block leaves it unassigned and infers a latch.
        for (int i = 0; i < NCH; i++) begin
            shadow_start_nxt[i] = shadow_start[i];
            shadow_stop_nxt[i]  = shadow_stop[i];
            if (cfg_we && (cfg_ch == CHW'(i))) begin
                shadow_start_nxt[i] = cfg_start;
                shadow_stop_nxt[i]  = cfg_stop;
            end
        end
    end

    // Window membership of the current phase; start >= stop never matches,
    // and bounds beyond the period are simply never reached.
    always_comb begin
        in_window = '0;
        for (int i = 0; i < NCH; i++) begin
            in_window[i] = (active_start[i] <= phase_q) && (phase_q < active_stop[i]);
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Phase counter and registered wrap pulse; reset beats sync_clear beats enable.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement or block order.
        if (reset) begin
            phase_q <= '0;
            wrap_q  <= 1'b0;
        end else if (sync_clear) begin
            phase_q <= '0;
            wrap_q  <= 1'b0;
        end else if (enable) begin
            phase_q <= at_last ? '0 : phase_q + NBITS'(1);
            wrap_q  <= at_last;
        end else begin
            wrap_q  <= 1'b0;
        end
    end

    // Completed-period counter, saturating; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycles_q <= '0;
        end else if (wrap_evt && (cycles_q != CYC_MAX)) begin
            cycles_q <= cycles_q + CYCW'(1);
        end
    end

    // Shadow window registers, written by the configuration port.
    always_ff @(posedge clk) begin
        // NOTE: the window register arrays are reset explicitly because a
        // cleared window (start = stop = 0) is the defined idle state of every
        // gate; they are small flop arrays, not RAM, so this is cheap.
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                shadow_start[i] <= '0;
                shadow_stop[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                shadow_start[i] <= shadow_start_nxt[i];
                shadow_stop[i]  <= shadow_stop_nxt[i];
            end
        end
    end

    // Active window registers, loaded from shadow only at a period boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                active_start[i] <= '0;
                active_stop[i]  <= '0;
            end
        end else if (transfer) begin
            for (int i = 0; i < NCH; i++) begin
                active_start[i] <= shadow_start_nxt[i];
                active_stop[i]  <= shadow_stop_nxt[i];
            end
        end
    end

    // Registered gates, one clock behind the phase they were evaluated on.
    always_ff @(posedge clk) begin
        if (reset) begin
            gate_q <= '0;
        end else begin
            gate_q <= in_window;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign count_out   = phase_q;
    assign wrap        = wrap_q;
    assign cycle_count = cycles_q;
    assign ch_out      = gate_q;

endmodule

// File: doc/phase_window_timer.md
Name: phase_window_timer

Overview:
- Free-running period counter for the FSM atomic clock sequence.
- Counts `clk` cycles modulo PERIOD and flags each period wrap.
- Counts completed periods.
- Drives NCH independent gate outputs, each high inside a programmable [start, stop) window of the period.
- Window configuration is double-buffered so timing changes only take effect at a period boundary.

Parameters:
- NBITS, 27: width of the phase counter and of the window start/stop values.
- PERIOD, 96830000: clocks per period; must be in the range 2..2^NBITS.
- NCH, 4: number of window channels; must be at least 1.
- CHW, 2: width of cfg_ch; must satisfy 2^CHW >= NCH.
- CYCW, 16: width of the completed-period counter.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: phase counter advances only while high.
- sync_clear, input, 1: restart the period at phase 0.
- cfg_we, input, 1: write strobe for the shadow window registers.
- cfg_ch, input, CHW: channel index for the write.
- cfg_start, input, NBITS: window start phase, inclusive.
- cfg_stop, input, NBITS: window stop phase, exclusive.
- count_out, output, NBITS: current phase, 0..PERIOD-1.
- wrap, output, 1: one-cycle pulse on a period wrap.
- cycle_count, output, CYCW: number of completed periods.
- ch_out, output, NCH: gate outputs, one bit per channel.

Behaviour:
- Reset (synchronous, active-high) clears:
  - count_out to 0, wrap to 0, cycle_count to 0, ch_out to all zeros;
  - every shadow and active start/stop register to 0.
- Priority, highest first: reset, then sync_clear, then enable.
- Phase counter:
  - With enable=1, count_out increments by 1 per clock.
  - At count_out==PERIOD-1 it wraps to 0 on the next clock, with no overshoot.
  - With enable=0, count_out holds.
- wrap is a registered pulse:
  - It is high for exactly the one cycle in which count_out first shows 0 after a PERIOD-1 to 0 transition.
  - At all other times, including after sync_clear or reset, it is 0.
- cycle_count:
  - Increments by 1 in the same clock edge that wraps the counter.
  - Saturates at 2^CYCW-1 and does not roll over.
  - Cleared only by reset; sync_clear leaves it unchanged.
- sync_clear:
  - On the next clock, count_out=0 and wrap=0, regardless of enable.
  - Active window registers are loaded from the shadow registers.
  - If asserted in the same cycle as a natural wrap, sync_clear wins: no wrap pulse and no cycle_count increment.
- Configuration writes:
  - With cfg_we=1 and cfg_ch<NCH, the shadow start/stop for that channel are written on the clock edge.
  - If cfg_ch>=NCH, the write is ignored.
  - Writes never touch active registers directly.
- Shadow to active transfer, all channels at once, happens on:
  - the edge on which the counter wraps;
  - any edge on which sync_clear=1.
  - A write in the same cycle as a transfer is included in that transfer, because the write data is forwarded.
- Channel gating:
  - ch_out[i] is registered.
  - It equals (active_start[i] <= count_out < active_stop[i]) evaluated on the previous cycle, i.e. one clock of latency relative to count_out.
  - Comparisons are unsigned, NBITS wide.
  - If start >= stop, the channel is disabled and ch_out[i] stays 0.
  - Windows do not span the wrap.
  - Start or stop values >= PERIOD are legal; the window is simply truncated at PERIOD-1.
- While enable=0, ch_out keeps re-evaluating against the held count, so the gate state is held.
- Reset asserted mid-period: all outputs are 0 on the next clock and the counter restarts from 0 once reset deasserts with enable=1.

Test Plan:
- Common setup: PERIOD=10, NBITS=4, NCH=2, CHW=1, CYCW=2.
- Free-run:
  - Stimulus: reset for 2 clocks, then enable=1 for 35 clocks.
  - Required: count_out follows 0..9,0..; wrap high exactly when count_out=0 at clocks 10, 20, 30; cycle_count reaches 3 and stays at 3 (saturated).
- Window gating:
  - Stimulus: while enable=0, write ch0 = [3,6) and ch1 = [0,10); pulse sync_clear, then enable.
  - Required: ch_out[0] high while count_out is 4, 5, 6 (one-cycle lag); ch_out[1] high from count_out=1 continuously.
- Double buffering:
  - Stimulus: with ch0 = [3,6), at count_out=4 write ch0 = [7,9).
  - Required: the current period still gates at 4..6; the next period gates at count_out 8, 9.
  - Required: same-cycle write at count_out=9 is applied in the next period.
- Disabled and invalid writes:
  - Stimulus: write ch0 = [5,5) and ch1 = [8,2); then write with cfg_ch=1 while NCH=1 in a second build.
  - Required: both channels stay 0 for the whole period; the out-of-range write changes nothing.
- Collisions:
  - Stimulus: assert sync_clear exactly when count_out=9, together with enable=1.
  - Required: next count_out=0, wrap=0, cycle_count unchanged.
  - Stimulus: enable=0 at count_out=5 for 3 clocks.
  - Required: count_out and ch_out hold.
- Mid-run reset:
  - Stimulus: reset at count_out=6 with windows set.
  - Required: next clock count_out=0, ch_out=0, cycle_count=0, active windows cleared.
